// File: rtl/lfsr_gen.sv
// Configurable Fibonacci/Galois LFSR with seed register, wrap detection and period measurement.
// Optional macro LFSR_LOCKUP_RECOVER_EN: a step from the all-zero state reloads SEED.
module lfsr_gen #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] FIB_TAPS = 4'b1100,
  parameter logic [WIDTH-1:0] GAL_TAPS = 4'b0011,
  parameter logic [WIDTH-1:0] SEED     = 4'b0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);

  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] q_next;
  logic             hit;

  function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & FIB_TAPS)};
  endfunction

  function automatic logic [WIDTH-1:0] gal_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? GAL_TAPS : '0);
  endfunction

  always_comb begin
    q_next = mode ? gal_step(q) : fib_step(q);
    hit    = (q_next == seed_q);
  end

  // State update: reset > load > step > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= SEED;
      seed_q <= SEED;
      cnt    <= '0;
      period <= '0;
      wrap   <= 1'b0;
    end else if (load) begin
      q      <= seed_in;
      seed_q <= seed_in;
      cnt    <= '0;
      wrap   <= 1'b0;
    end else if (en) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (q == '0) begin
        q      <= SEED;
        seed_q <= SEED;
        cnt    <= '0;
        wrap   <= 1'b0;
      end else begin
`else
      begin
`endif
        q    <= q_next;
        wrap <= hit;
        if (hit) begin
          cnt    <= '0;
          period <= cnt + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign lockup = (q == '0);

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 4: register width in bits; legal range 2..32.
REQ-002 Parameter FIB_TAPS, default 4'b1100: Fibonacci tap mask, WIDTH bits.
REQ-003 Parameter GAL_TAPS, default 4'b0011: Galois feedback mask, WIDTH bits.
REQ-004 Parameter SEED, default 4'b0001: reset value of q and of the seed register; must be nonzero.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  advance the LFSR one step this cycle.
REQ-008 load  input  1  load seed_in into q and into the seed register.
REQ-009 seed_in  input  WIDTH  seed value, sampled when load=1.
REQ-010 mode  input  1  0 = Fibonacci, 1 = Galois; sampled on every step.
REQ-011 q  output  WIDTH  current LFSR state (registered).
REQ-012 wrap  output  1  one-cycle pulse: the last step returned q to the seed register value.
REQ-013 period  output  WIDTH  step count of the last completed cycle; 0 until the first wrap.
REQ-014 lockup  output  1  high while q == 0 (combinational from q).

Function
REQ-015 Priority each edge: reset > load > en > hold.
REQ-016 Fibonacci step: fb = XOR-reduce(q & FIB_TAPS); q_next = {q[WIDTH-2:0], fb}.
REQ-017 Galois step: q_next = {q[WIDTH-2:0], 1'b0} XOR (q[WIDTH-1] ? GAL_TAPS : 0).
REQ-018 A step (en=1, load=0) updates q to q_next within 1 cycle; en=0 and load=0 holds q, cnt, period.
REQ-019 A mode change takes effect on the next step; q is not modified by the mode change itself.
REQ-020 Internal seed register seed_q: SEED on reset; seed_in on load.
REQ-021 Internal step counter cnt (WIDTH bits): 0 on reset or load; on a step, if q_next == seed_q then cnt <= 0 and period <= cnt+1, otherwise cnt <= cnt+1.
REQ-022 wrap is registered: 1 in the cycle after a step with q_next == seed_q; 0 after load, hold, or reset.
REQ-023 load with en=1 in the same cycle: the load wins; no step occurs; wrap=0; period is unchanged.
REQ-024 cnt wraps modulo 2^WIDTH without a flag; this happens only for non-maximal tap sets.
REQ-025 load with seed_in = 0 is legal; q = 0 and lockup = 1 follow.

Reset
REQ-026 On reset: q = SEED, seed_q = SEED, cnt = 0, period = 0, wrap = 0; lockup therefore = 0.
REQ-027 Reset asserted mid-run overrides load and en in the same cycle; stepping resumes from SEED on the first edge after reset is released.

Configuration
REQ-028 Macro LFSR_LOCKUP_RECOVER_EN defined: a step with q == 0 loads q <= SEED and seed_q <= SEED, and clears cnt; lockup is high only until that step.
REQ-029 Macro LFSR_LOCKUP_RECOVER_EN undefined: a step with q == 0 leaves q = 0 and lockup stays high until reset or a nonzero load; cnt and wrap follow REQ-021/022 (q_next == 0).

Verification
REQ-030 Reset 1 cycle, mode=0, en=1 -> q sequence 0001,0010,0100,1001,0011,0110,1101,...; wrap pulses after step 15; period = 15.
REQ-031 Reset, mode=1, en=1 -> q sequence 0001,0010,0100,1000,0011,0110,1100,1011,...; wrap after step 15; period = 15.
REQ-032 Mid-run en=0 for 5 cycles -> q, period, and wrap hold (wrap=0); stepping resumes with the correct next value.
REQ-033 load=1, en=1, seed_in=4'b1010 -> q=1010 next cycle, wrap=0; a further 15 steps -> wrap=1, period=15.
REQ-034 load seed_in=0 then en=1 for 3 cycles -> without macro: q=0 and lockup=1 throughout; with macro: q=0001 after the first step and lockup=0.
REQ-035 Reset asserted with load=1 and en=1 mid-sequence -> q=0001, period=0, wrap=0 on the next cycle.
